// File: rtl/wb_charlie7x5_frames.sv
// Double-buffered frame scheduler for the 7x5 charlieplexed LED display.
//
// The CPU fills the back bank (5 rows x 7 bits) through a pipelined Wishbone
// slave, then sets a swap request. On the next frame tick the banks swap and
// the block pushes the five front rows to the display peripheral through a
// pipelined Wishbone master (addresses 0..4). The display never sees a
// half-written frame.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   s_wb_*               CPU-facing slave: adr 0..4 back rows, adr 5 control/status
//   m_wb_*               display-facing master: row writes {25'b0, row}
module wb_charlie7x5_frames #(
  parameter int unsigned WB_CLK_HZ = 48_000_000,
  parameter int unsigned FRAME_HZ  = 50
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  input  logic        s_wb_we_i,
  input  logic [2:0]  s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_stall_o,
  output logic        s_wb_ack_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [3:0]  m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic        m_wb_stall_i,
  input  logic        m_wb_ack_i
);

  localparam int unsigned DIV = WB_CLK_HZ / FRAME_HZ;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      acks_q, acks_d;
  logic [2:0]      acks_inc;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            sel;
  logic            swap_pending;
  logic            swap;
  logic            busy;
  logic            s_req;
  logic [31:0]     rd_data;
  logic [6:0]      bank [2][5];

  // Only bit 0 (swap request) and bits 6:0 (row data) carry meaning.
  logic            unused_dat_hi;
  assign unused_dat_hi = ^s_wb_dat_i[31:7];

  assign s_req        = s_wb_cyc_i & s_wb_stb_i;
  assign s_wb_stall_o = 1'b0;
  assign m_wb_we_o    = 1'b1;

  assign tick = (tick_cnt == '0);
  assign busy = (state_q != IDLE);
  // swap_pending is the registered value, so a request written on the tick
  // cycle itself only qualifies for the following tick.
  assign swap = tick & swap_pending & (state_q == IDLE);

  always_comb begin
    rd_data = '0;
    if (s_wb_adr_i < 3'd5) begin
      rd_data = {25'b0, bank[~sel][s_wb_adr_i]};
    end else if (s_wb_adr_i == 3'd5) begin
      rd_data = {30'b0, swap_pending, busy};
    end
  end

  // A row write on the swap cycle targets the bank that is about to become
  // front (old ~sel), so it is part of the frame being pushed.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tick_cnt     <= RELOAD;
      sel          <= 1'b0;
      swap_pending <= 1'b0;
      s_wb_ack_o   <= 1'b0;
      s_wb_dat_o   <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      acks_q       <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned r = 0; r < 5; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else begin
      tick_cnt   <= tick ? RELOAD : tick_cnt - 1'b1;
      state_q    <= state_d;
      idx_q      <= idx_d;
      acks_q     <= acks_d;
      s_wb_ack_o <= s_req;

      if (swap) begin
        sel          <= ~sel;
        swap_pending <= 1'b0;
      end

      if (s_req && s_wb_we_i) begin
        if (s_wb_adr_i < 3'd5) begin
          bank[~sel][s_wb_adr_i] <= s_wb_dat_i[6:0];
        end else if (s_wb_adr_i == 3'd5 && s_wb_dat_i[0]) begin
          swap_pending <= 1'b1;
        end
      end

      if (s_req && !s_wb_we_i) begin
        s_wb_dat_o <= rd_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acks_d     = acks_q;
    m_wb_cyc_o = 1'b0;
    m_wb_stb_o = 1'b0;
    m_wb_adr_o = '0;
    m_wb_dat_o = '0;
    acks_inc   = acks_q + {2'b0, m_wb_ack_i};

    case (state_q)
      IDLE: begin
        if (swap) begin
          state_d = SEND;
          idx_d   = '0;
          acks_d  = '0;
        end
      end
      SEND: begin
        m_wb_cyc_o = 1'b1;
        m_wb_stb_o = 1'b1;
        m_wb_adr_o = {1'b0, idx_q};
        m_wb_dat_o = {25'b0, bank[sel][idx_q]};
        acks_d     = acks_inc;
        if (!m_wb_stall_i) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            // A zero-latency display may deliver the last ack with the last strobe.
            state_d = (acks_inc == 3'd5) ? IDLE : WAIT;
          end
        end
      end
      WAIT: begin
        m_wb_cyc_o = 1'b1;
        acks_d     = acks_inc;
        if (acks_inc == 3'd5) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_charlie7x5_frames.sv
// Directed bench for wb_charlie7x5_frames with DIV = 10 and a display model
// that acks one cycle after each accepted strobe.
module tb_wb_charlie7x5_frames;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        s_wb_cyc_i, s_wb_stb_i, s_wb_we_i;
  logic [2:0]  s_wb_adr_i;
  logic [31:0] s_wb_dat_i;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_stall_o, s_wb_ack_o;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
  logic [3:0]  m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_stall_i;
  logic        m_wb_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_charlie7x5_frames #(
    .WB_CLK_HZ(1000),
    .FRAME_HZ (100)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .s_wb_cyc_i  (s_wb_cyc_i),
    .s_wb_stb_i  (s_wb_stb_i),
    .s_wb_we_i   (s_wb_we_i),
    .s_wb_adr_i  (s_wb_adr_i),
    .s_wb_dat_i  (s_wb_dat_i),
    .s_wb_dat_o  (s_wb_dat_o),
    .s_wb_stall_o(s_wb_stall_o),
    .s_wb_ack_o  (s_wb_ack_o),
    .m_wb_cyc_o  (m_wb_cyc_o),
    .m_wb_stb_o  (m_wb_stb_o),
    .m_wb_we_o   (m_wb_we_o),
    .m_wb_adr_o  (m_wb_adr_o),
    .m_wb_dat_o  (m_wb_dat_o),
    .m_wb_stall_i(m_wb_stall_i),
    .m_wb_ack_i  (m_wb_ack_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Display model: acks one cycle after acceptance; optional 3-cycle stall
  // applied to the strobe that follows strobe 0.
  logic [1:0] stall_left = 2'd0;
  logic       disp_ack = 1'b0;
  bit         stall_mode = 1'b0;
  assign m_wb_stall_i = (stall_left != 2'd0);
  assign m_wb_ack_i   = disp_ack;

  always @(posedge wb_clk_i) begin
    disp_ack <= m_wb_cyc_o && m_wb_stb_o && !m_wb_stall_i;
    if (stall_mode && m_wb_cyc_o && m_wb_stb_o && !m_wb_stall_i && m_wb_adr_o == 4'd0)
      stall_left <= 2'd3;
    else if (stall_left != 2'd0)
      stall_left <= stall_left - 2'd1;
  end

  // Scoreboard of expected master writes.
  typedef struct packed {
    logic [3:0]  adr;
    logic [31:0] dat;
  } mexp_t;
  mexp_t        mq[$];
  logic [31:0]  rq[$];

  int cyc_n = 0, last_rise = 0, prev_rise = 0;
  int ack_cnt = 0, adr1_cycles = 0, extra_strobes = 0;
  logic cyc_prev = 1'b0;

  always @(negedge wb_clk_i) begin
    mexp_t e;
    cyc_n++;
    if (m_wb_cyc_o === 1'b1 && cyc_prev !== 1'b1) begin
      prev_rise = last_rise;
      last_rise = cyc_n;
    end
    cyc_prev = m_wb_cyc_o;
    if (m_wb_cyc_o === 1'b1 && m_wb_ack_i) ack_cnt++;
    if (m_wb_cyc_o === 1'b1 && m_wb_stb_o === 1'b1 && m_wb_adr_o == 4'd1) adr1_cycles++;
    if (m_wb_cyc_o === 1'b1 && m_wb_stb_o === 1'b1 && !m_wb_stall_i) begin
      if (mq.size() == 0) begin
        extra_strobes++;
      end else begin
        e = mq.pop_front();
        chk("m_adr", {28'b0, m_wb_adr_o}, {28'b0, e.adr});
        chk("m_dat", m_wb_dat_o, e.dat);
        chk("m_we", {31'b0, m_wb_we_o}, 32'd1);
      end
    end
  end

  task automatic push_exp(input logic [3:0] a, input logic [6:0] d);
    mexp_t e;
    e.adr = a;
    e.dat = {25'b0, d};
    mq.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
    @(negedge wb_clk_i);
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b1;
    s_wb_adr_i = a; s_wb_dat_i = d;
    @(negedge wb_clk_i);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    chk({tag, "_ack"}, {31'b0, s_wb_ack_o}, 32'd1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    @(negedge wb_clk_i);
    s_wb_cyc_i = 1'b1; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b0;
    s_wb_adr_i = a; s_wb_dat_i = '0;
    rq.push_back(exp);
    @(negedge wb_clk_i);
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0;
    chk({tag, "_ack"}, {31'b0, s_wb_ack_o}, 32'd1);
    e = rq.pop_front();
    chk(tag, s_wb_dat_o, e);
  endtask

  task automatic wait_cyc(input logic lvl, input int unsigned bound, input string tag);
    int unsigned n = 0;
    while (m_wb_cyc_o !== lvl && n < bound) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk(tag, {31'b0, m_wb_cyc_o}, {31'b0, lvl});
  endtask

  logic [6:0] pat_p [5];
  logic [6:0] pat_s [5];
  logic [6:0] pat_a [5];
  logic [6:0] pat_r [5];

  initial begin
    int unsigned n;
    int cyc_seen;
    pat_p = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    pat_s = '{7'h41, 7'h02, 7'h43, 7'h44, 7'h45};
    pat_a = '{7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E};
    pat_r = '{7'h11, 7'h12, 7'h13, 7'h14, 7'h15};

    wb_rst_i = 1'b1;
    s_wb_cyc_i = 1'b0; s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
    s_wb_adr_i = '0; s_wb_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_s_ack", {31'b0, s_wb_ack_o}, 32'd0);
    chk("rst_s_dat", s_wb_dat_o, 32'd0);
    chk("rst_m_cyc", {31'b0, m_wb_cyc_o}, 32'd0);
    chk("rst_m_stb", {31'b0, m_wb_stb_o}, 32'd0);
    chk("rst_m_adr", {28'b0, m_wb_adr_o}, 32'd0);
    chk("rst_m_dat", m_wb_dat_o, 32'd0);
    chk("s_stall", {31'b0, s_wb_stall_o}, 32'd0);
    wb_rst_i = 1'b0;

    // Idle after reset: no push, status clear.
    for (int i = 0; i < 30; i++) begin
      @(negedge wb_clk_i);
      chk("idle_cyc", {31'b0, m_wb_cyc_o}, 32'd0);
    end
    rd(3'd5, 32'd0, "status_reset");

    // First swap: rows pushed in order, status busy during push.
    for (int unsigned r = 0; r < 5; r++) begin
      wr(3'(r), {25'b0, pat_p[r]}, "row_wr");
      push_exp(4'(r), pat_p[r]);
    end
    ack_cnt = 0; adr1_cycles = 0;
    wr(3'd5, 32'd1, "swap_req1");
    wait_cyc(1'b1, 30, "push1_start");
    rd(3'd5, 32'd1, "status_busy");
    wait_cyc(1'b0, 30, "push1_end");
    @(negedge wb_clk_i);
    chk("push1_acks", ack_cnt, 32'd5);
    chk("push1_left", mq.size(), 32'd0);
    chk("push1_adr1_cycles", adr1_cycles, 32'd1);
    rd(3'd5, 32'd0, "status_done");

    // Back bank after first swap holds the old (all-zero) front.
    for (int unsigned r = 0; r < 5; r++) rd(3'(r), 32'd0, "back_zero");

    // Stalled second strobe.
    for (int unsigned r = 0; r < 5; r++) begin
      wr(3'(r), {25'b0, pat_s[r]}, "row_wr");
      push_exp(4'(r), pat_s[r]);
    end
    stall_mode = 1'b1;
    ack_cnt = 0; adr1_cycles = 0;
    wr(3'd5, 32'd1, "swap_req2");
    wait_cyc(1'b1, 30, "push2_start");
    wait_cyc(1'b0, 40, "push2_end");
    @(negedge wb_clk_i);
    stall_mode = 1'b0;
    chk("push2_adr1_cycles", adr1_cycles, 32'd4);
    chk("push2_acks", ack_cnt, 32'd5);
    chk("push2_left", mq.size(), 32'd0);
    for (int unsigned r = 0; r < 5; r++) rd(3'(r), {25'b0, pat_p[r]}, "back_prev_front");

    // Swap request during a push waits for the following tick.
    for (int unsigned r = 0; r < 5; r++) begin
      wr(3'(r), {25'b0, pat_a[r]}, "row_wr");
      push_exp(4'(r), pat_a[r]);
    end
    for (int unsigned r = 0; r < 5; r++) push_exp(4'(r), pat_s[r]);
    wr(3'd5, 32'd1, "swap_req3");
    wait_cyc(1'b1, 30, "push3_start");
    wr(3'd5, 32'd1, "swap_req_busy");
    wait_cyc(1'b0, 30, "push3_end");
    rd(3'd5, 32'd2, "status_pending");
    wait_cyc(1'b1, 30, "push4_start");
    wait_cyc(1'b0, 30, "push4_end");
    @(negedge wb_clk_i);
    chk("swap_gap", last_rise - prev_rise, 32'd10);
    chk("push4_left", mq.size(), 32'd0);
    for (int unsigned r = 0; r < 5; r++) rd(3'(r), {25'b0, pat_a[r]}, "back_after_4");

    // Reset in the cycle after the second strobe is accepted.
    for (int unsigned r = 0; r < 5; r++) wr(3'(r), {25'b0, pat_r[r]}, "row_wr");
    for (int unsigned r = 0; r < 3; r++) push_exp(4'(r), pat_r[r]);
    wr(3'd5, 32'd1, "swap_req5");
    wait_cyc(1'b1, 30, "push5_start");
    n = 0;
    while (!(m_wb_stb_o === 1'b1 && !m_wb_stall_i && m_wb_adr_o == 4'd1) && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("strobe2_seen", {28'b0, m_wb_adr_o}, 32'd1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk("midrst_cyc", {31'b0, m_wb_cyc_o}, 32'd0);
    chk("midrst_stb", {31'b0, m_wb_stb_o}, 32'd0);
    for (int unsigned r = 0; r < 5; r++) rd(3'(r), 32'd0, "row_after_rst");
    rd(3'd5, 32'd0, "status_after_rst");
    repeat (30) @(negedge wb_clk_i);
    chk("rst_left", mq.size(), 32'd0);
    chk("extra_strobes_rst", extra_strobes, 32'd0);

    // Ignored addresses, no-op swap write, high data bits ignored.
    wr(3'd6, 32'hFFFF_FFFF, "wr_adr6");
    wr(3'd5, 32'd0, "wr_swap0");
    wr(3'd0, 32'hFFFF_FF85, "wr_row_hi");
    rd(3'd6, 32'd0, "rd_adr6");
    rd(3'd0, 32'd5, "rd_row_masked");
    @(negedge wb_clk_i);
    chk("ack_single", {31'b0, s_wb_ack_o}, 32'd0);
    cyc_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge wb_clk_i);
      if (m_wb_cyc_o !== 1'b0) cyc_seen++;
    end
    chk("no_swap_cyc", cyc_seen, 32'd0);
    rd(3'd5, 32'd0, "status_final");
    chk("extra_strobes_final", extra_strobes, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_charlie7x5_frames.md
Name: wb_charlie7x5_frames

Overview:
Double-buffered frame scheduler for the 7x5 charlieplexed LED display peripheral.
- CPU side: a Wishbone B4 pipelined slave. The CPU fills a back buffer of 5 rows x 7 bits, then requests a swap.
- On the next frame tick the block swaps buffers. It then acts as a Wishbone B4 pipelined master and pushes the 5 front rows to the display peripheral (addresses 0..4).
- The display therefore never shows a half-written frame.

Parameters:
- WB_CLK_HZ, 48_000_000, system clock frequency in Hz.
- FRAME_HZ, 50, frame tick rate. DIV = WB_CLK_HZ/FRAME_HZ, must be >= 2.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous reset, active high
- s_wb_cyc_i  in  1  slave cycle
- s_wb_stb_i  in  1  slave strobe
- s_wb_we_i  in  1  slave write enable
- s_wb_adr_i  in  3  slave word address
- s_wb_dat_i  in  32  slave write data
- s_wb_dat_o  out  32  slave read data
- s_wb_stall_o  out  1  slave stall, constant 0
- s_wb_ack_o  out  1  slave acknowledge
- m_wb_cyc_o  out  1  master cycle to display
- m_wb_stb_o  out  1  master strobe
- m_wb_we_o  out  1  master write enable, constant 1
- m_wb_adr_o  out  4  master address: row index 0..4, bit 3 always 0
- m_wb_dat_o  out  32  master data: {25'b0, row[6:0]}
- m_wb_stall_i  in  1  display stall
- m_wb_ack_i  in  1  display acknowledge

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high. On reset, all of the following clear to 0:
  - both buffers, sel, swap_pending, FSM state (IDLE);
  - all master outputs except we;
  - s_wb_ack_o and s_wb_dat_o.
  - The tick counter loads DIV-1.
- Reset mid-push: m_wb_cyc_o and m_wb_stb_o drop to 0 the cycle after reset is sampled. The transfer is abandoned; outstanding acks are ignored.
- Buffers: two banks of 5 x 7 bits. buf[sel] is the front bank, buf[~sel] is the back bank.
- Slave request = cyc && stb. s_wb_ack_o is registered, exactly one cycle after each request. s_wb_stall_o is always 0.
- Slave writes:
  - adr 0..4: back[adr] <= dat[6:0].
  - adr 5: if dat[0]=1, swap_pending <= 1. dat[0]=0 has no effect.
  - adr 6..7: ignored.
- Slave reads, registered alongside the ack:
  - adr 0..4: {25'b0, back[adr]}.
  - adr 5: {30'b0, swap_pending, busy}, where busy = (state != IDLE).
  - adr 6..7: 0.
- Tick counter: decrements every cycle. When it reaches 0, tick=1 for one cycle and the counter reloads DIV-1.
- Swap: on a tick with swap_pending=1 and state IDLE:
  - sel toggles, swap_pending clears, the FSM enters SEND with idx=0, acks=0.
  - The new back bank keeps the previous front contents.
  - Tick while busy, or tick without pending: no action. A pending swap waits for the next qualifying tick.
- Simultaneous events:
  - A slave write to adr 5 in the same cycle as a qualifying tick does not count for that tick. swap_pending is 1 afterwards.
  - A back-bank write on the swap cycle lands in the pre-swap back bank, which becomes front. The write is visible in this push.
- Master FSM:
  - IDLE: cyc=0, stb=0.
  - SEND: cyc=1, stb=1, adr=idx, dat=front[idx]. Each cycle with stall=0 accepts one strobe and increments idx. When strobe idx=4 is accepted, go to WAIT.
  - WAIT: cyc=1, stb=0. Hold until the total acks counted (from SEND onward) reach 5, then go to IDLE with cyc=0 on the next cycle.
  - Acks arriving during SEND are counted.
  - Minimum push: 5 strobe cycles plus the final ack latency.
- Width rules: idx and acks are 3 bits. Slave data bits 31:7 are ignored on row writes.

Test Plan:
Bench uses WB_CLK_HZ=1000, FRAME_HZ=100 (DIV=10), and a display model that acks 1 cycle after each accepted strobe.
1. Reset, then idle 30 cycles -> m_wb_cyc_o stays 0. Reading adr 5 returns 0.
2. Write rows 0..4 = 7'h01,02,04,08,10, then write adr 5 = 1 -> at the next tick, exactly 5 master writes (adr 0..4, those data values, stall low). Status reads busy during the push, then 0. swap_pending reads 0 after the tick.
3. Display model holds stall=1 for 3 cycles on the 2nd strobe -> adr/dat remain 1/7'h02 for 4 cycles. Total strobes = 5; cyc drops only after the 5th ack.
4. After a swap, read back rows 0..4 -> returns the previous front (all 0 after the first swap). Write adr 5 = 1 during a push -> the push completes; the next swap happens at the following tick.
5. Assert wb_rst_i in the cycle after the 2nd strobe is accepted -> cyc/stb are 0 the next cycle. Reading rows returns 0 and status returns 0. No further strobes.
6. Write adr 6 = 32'hFFFF_FFFF and adr 5 = 0 -> no swap at the next tick. Reading adr 6 returns 0. Each slave request is acked exactly 1 cycle later.
